// File: rtl/lpf_decimator.sv
// lpf_decimator
// Block-average decimator placed after the Tustin low-pass filter. It sums
// non-overlapping blocks of R = 2^log2_ratio samples and presents the
// arithmetic-shifted average on a valid/ready output. The input side has no
// back-pressure: every in_valid sample is taken. If a result is replaced
// before downstream takes it, the sticky overrun flag is set.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   in             signed filtered sample (DATA_BITS)
//   in_valid       sample strobe, one sample accepted per edge while high
//   log2_ratio     log2 of the decimation ratio. Values above MAX_LOG2_RATIO
//                  are clamped to MAX_LOG2_RATIO.
//   clear          discards the partial block (wins over in_valid)
//   out            signed block average (DATA_BITS)
//   out_valid      out holds an unconsumed result
//   out_ready      downstream accepts out when out_valid & out_ready
//   overrun        sticky: an unconsumed result was overwritten
//   overrun_clear  clears overrun (a new overrun on the same edge wins)
module lpf_decimator #(
  parameter int DATA_BITS      = 32,
  parameter int MAX_LOG2_RATIO = 10,
  parameter int RATIO_BITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_BITS-1:0]  in,
  input  logic                  in_valid,
  input  logic [RATIO_BITS-1:0] log2_ratio,
  input  logic                  clear,
  output logic [DATA_BITS-1:0]  out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  input  logic                  overrun_clear
);

  localparam int ACC_BITS = DATA_BITS + MAX_LOG2_RATIO;
  // One extra bit so the counter can hold 2^MAX_LOG2_RATIO - 1 and the
  // one-hot 1 << MAX_LOG2_RATIO without truncation.
  localparam int CNT_BITS = MAX_LOG2_RATIO + 1;

  // Clamp the requested ratio to the largest supported value.
  function automatic logic [RATIO_BITS-1:0] clamp_ratio(input logic [RATIO_BITS-1:0] r);
    if (r > RATIO_BITS'(MAX_LOG2_RATIO)) begin
      return RATIO_BITS'(MAX_LOG2_RATIO);
    end else begin
      return r;
    end
  endfunction

  logic [CNT_BITS-1:0]          count;
  logic signed [ACC_BITS-1:0]   acc;
  logic [RATIO_BITS-1:0]        ratio;

  logic [RATIO_BITS-1:0]        clamped;
  logic [RATIO_BITS-1:0]        eff_ratio;
  logic [CNT_BITS-1:0]          last_idx;
  logic                         last;
  logic signed [ACC_BITS-1:0]   in_ext;
  logic signed [ACC_BITS-1:0]   sum;
  logic signed [ACC_BITS-1:0]   shifted;
  logic [DATA_BITS-1:0]         result;
  logic                         accept;
  logic                         new_result;

  // Datapath: effective ratio, block-end detect and the running/final sum.
  always_comb begin
    clamped    = clamp_ratio(log2_ratio);
    // The first sample of a block uses the ratio captured on that same edge.
    eff_ratio  = (count == {CNT_BITS{1'b0}}) ? clamped : ratio;
    last_idx   = (CNT_BITS'(1) << eff_ratio) - CNT_BITS'(1);
    last       = (count == last_idx);
    in_ext     = {{MAX_LOG2_RATIO{in[DATA_BITS-1]}}, in};
    sum        = ((count == {CNT_BITS{1'b0}}) ? {ACC_BITS{1'b0}} : acc) + in_ext;
    shifted    = sum >>> eff_ratio;
    result     = shifted[DATA_BITS-1:0];
    accept     = in_valid & ~clear;
    new_result = accept & last;
  end

  // Block accumulation state: counter, partial sum and latched ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CNT_BITS{1'b0}};
      acc   <= {ACC_BITS{1'b0}};
      ratio <= {RATIO_BITS{1'b0}};
    end else if (clear) begin
      count <= {CNT_BITS{1'b0}};
      acc   <= {ACC_BITS{1'b0}};
    end else if (in_valid) begin
      if (count == {CNT_BITS{1'b0}}) begin
        ratio <= clamped;
      end
      if (last) begin
        count <= {CNT_BITS{1'b0}};
        acc   <= {ACC_BITS{1'b0}};
      end else begin
        count <= count + CNT_BITS'(1);
        acc   <= sum;
      end
    end
  end

  // Output register and handshake; a new result always replaces out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= {DATA_BITS{1'b0}};
      out_valid <= 1'b0;
    end else if (new_result) begin
      out       <= result;
      out_valid <= 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun: set when an unconsumed result is overwritten; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (new_result & out_valid & ~out_ready) begin
      overrun <= 1'b1;
    end else if (overrun_clear) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lpf_decimator.sv
// tb_lpf_decimator
// Directed bench for lpf_decimator. Inputs are driven 1 ns after a rising
// edge. Outputs are checked 1 ns after the next rising edge, against values
// worked out by hand.
module tb_lpf_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic        in_valid;
  logic [3:0]  log2_ratio;
  logic        clear;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        overrun_clear;

  int checks   = 0;
  int failures = 0;

  lpf_decimator #(.DATA_BITS(32), .MAX_LOG2_RATIO(10), .RATIO_BITS(4)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .log2_ratio(log2_ratio),
    .clear(clear), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .overrun_clear(overrun_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one sample for one edge, then drop in_valid.
  task automatic send(input logic [31:0] d);
    in = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in = 32'd0; in_valid = 1'b0; log2_ratio = 4'd0; clear = 1'b0;
    out_ready = 1'b0; overrun_clear = 1'b0;
    idle(); idle();
    check("reset_out", out, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // R=4: (4+8+12+16)/4 = 10, valid for exactly one cycle
    log2_ratio = 4'd2;
    send(32'd4);   check("r4_v1", {31'd0, out_valid}, 32'd0);
    send(32'd8);   check("r4_v2", {31'd0, out_valid}, 32'd0);
    send(32'd12);  check("r4_v3", {31'd0, out_valid}, 32'd0);
    send(32'd16);  check("r4_v4", {31'd0, out_valid}, 32'd1);
    check("r4_out", out, 32'd10);
    idle();        check("r4_drop", {31'd0, out_valid}, 32'd0);
    check("r4_hold", out, 32'd10);

    // R=2: -3 >>> 1 = -2, and no wrap at full scale
    log2_ratio = 4'd1;
    send(32'hFFFF_FFFF); check("neg_v1", {31'd0, out_valid}, 32'd0);
    send(32'hFFFF_FFFE); check("neg_out", out, 32'hFFFF_FFFE);
    check("neg_valid", {31'd0, out_valid}, 32'd1);
    send(32'h7FFF_FFFF); check("max_v1", {31'd0, out_valid}, 32'd0);
    send(32'h7FFF_FFFF); check("max_out", out, 32'h7FFF_FFFF);
    idle();

    // R=1 pass-through, back to back
    log2_ratio = 4'd0;
    send(32'd5);         check("pt_out0", out, 32'd5);
    check("pt_valid0", {31'd0, out_valid}, 32'd1);
    send(32'hFFFF_FFF9); check("pt_out1", out, 32'hFFFF_FFF9);
    check("pt_valid1", {31'd0, out_valid}, 32'd1);
    send(32'd9);         check("pt_out2", out, 32'd9);
    check("pt_valid2", {31'd0, out_valid}, 32'd1);
    check("pt_overrun", {31'd0, overrun}, 32'd0);
    idle();              check("pt_drop", {31'd0, out_valid}, 32'd0);

    // Overrun: out_ready low, second result overwrites the first
    log2_ratio = 4'd1;
    out_ready = 1'b0;
    send(32'd2); send(32'd2);
    check("ovr_out1", out, 32'd2);
    check("ovr_ovr1", {31'd0, overrun}, 32'd0);
    send(32'd6); check("ovr_held", out, 32'd2);
    send(32'd6); check("ovr_out2", out, 32'd6);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_valid", {31'd0, out_valid}, 32'd1);
    overrun_clear = 1'b1;
    idle();
    overrun_clear = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    check("ovr_valid_kept", {31'd0, out_valid}, 32'd1);
    // A new overrun and overrun_clear on the same edge: the set wins
    log2_ratio = 4'd0;
    overrun_clear = 1'b1;
    send(32'd8);
    overrun_clear = 1'b0;
    check("ovr_set_wins", {31'd0, overrun}, 32'd1);
    check("ovr_out3", out, 32'd8);
    overrun_clear = 1'b1; idle(); overrun_clear = 1'b0;
    out_ready = 1'b1;
    idle(); check("ovr_drain", {31'd0, out_valid}, 32'd0);
    check("ovr_final", {31'd0, overrun}, 32'd0);

    // A ratio change in mid-block applies from the next block
    log2_ratio = 4'd2;
    send(32'd1); send(32'd1);
    log2_ratio = 4'd1;
    send(32'd1); check("rc_mid", {31'd0, out_valid}, 32'd0);
    send(32'd1); check("rc_old_out", out, 32'd1);
    check("rc_old_valid", {31'd0, out_valid}, 32'd1);
    send(32'd3); check("rc_v", {31'd0, out_valid}, 32'd0);
    send(32'd5); check("rc_new_out", out, 32'd4);
    idle();

    // Reset in mid-block discards 100+100; a gap inside the block is allowed
    log2_ratio = 4'd2;
    send(32'd100); send(32'd100);
    rst = 1'b1; idle(); rst = 1'b0;
    check("rst_out", out, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    send(32'd1); send(32'd2); idle(); send(32'd3);
    check("rst_gap_v", {31'd0, out_valid}, 32'd0);
    check("rst_gap_out", out, 32'd0);
    send(32'd6); check("rst_out2", out, 32'd3);
    check("rst_valid2", {31'd0, out_valid}, 32'd1);
    idle();

    // clear together with in_valid: the sample is dropped, out is untouched
    send(32'd100); send(32'd100);
    clear = 1'b1; send(32'd50); clear = 1'b0;
    check("clr_out", out, 32'd3);
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    send(32'd4); send(32'd4); send(32'd8);
    check("clr_v", {31'd0, out_valid}, 32'd0);
    send(32'd8); check("clr_out2", out, 32'd6);
    idle();

    // Clamp: log2_ratio=15 acts as 10, so a block is 1024 samples
    log2_ratio = 4'd15;
    for (int i = 0; i < 1023; i++) begin
      send(32'hFFFF_FFFD);
    end
    check("clamp_v", {31'd0, out_valid}, 32'd0);
    send(32'hFFFF_FFFD);
    check("clamp_out", out, 32'hFFFF_FFFD);
    check("clamp_valid", {31'd0, out_valid}, 32'd1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpf_decimator.md
Name: lpf_decimator

Overview:
Block-average decimator directly downstream of the Tustin low-pass filter. It consumes the filter's full-width output and its valid strobe, and averages non-overlapping blocks of 2^log2_ratio samples. It emits one averaged sample per block to the readout/packer stage over a valid/ready handshake. Its input is never back-pressured, because the filter has no ready. Output loss is flagged with a sticky overrun bit.

Parameters:
DATA_BITS, 32, width of signed input/output samples (Q1.DATA_BITS-1, matches filter OUTPUT_BITS)
MAX_LOG2_RATIO, 10, largest supported log2 of decimation ratio; accumulator width ACC_BITS = DATA_BITS + MAX_LOG2_RATIO
RATIO_BITS, 4, width of log2_ratio port (must satisfy 2^RATIO_BITS > MAX_LOG2_RATIO)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in  in  DATA_BITS  signed filtered sample
in_valid  in  1  sample strobe; a sample is accepted on every clk edge where in_valid=1
log2_ratio  in  RATIO_BITS  decimation ratio R = 2^log2_ratio; values > MAX_LOG2_RATIO are clamped to MAX_LOG2_RATIO
clear  in  1  synchronous pulse that discards the partial block
out  out  DATA_BITS  signed block average
out_valid  out  1  out holds an unconsumed result
out_ready  in  1  downstream accepts out when out_valid & out_ready
overrun  out  1  sticky: an unconsumed result was overwritten
overrun_clear  in  1  clears overrun

Behaviour:
- Reset (rst=1 at a clk edge): out=0, out_valid=0, overrun=0. Internally, sample count=0, acc=0, latched ratio=0.
- Ratio latch:
  - log2_ratio (after clamping) is captured into the latched ratio when the first sample of a block is accepted (count==0 & in_valid).
  - A change to log2_ratio in mid-block takes effect at the next block.
- Accumulation, on each accepted sample:
  - count==0: acc <= sign-extended in.
  - otherwise: acc <= acc + sign-extended in.
  - count increments. Sign extension is to ACC_BITS; no overflow is possible.
- Block end: the accepted sample is the last of the block (count == R-1, using the ratio in effect for that block, including one captured on this same edge).
  - result = (acc + in) >>> ratio (arithmetic shift; truncates toward minus infinity), taking the low DATA_BITS bits.
  - out <= result, out_valid <= 1, count <= 0.
- Latency: out_valid rises on the clk edge that accepts the R-th sample. It is visible 1 cycle after the R-th sample is presented.
- log2_ratio=0: pass-through; each accepted sample appears on out one cycle later.
- Handshake:
  - While out_valid=1 and out_ready=0, out is held stable.
  - At an edge with out_valid & out_ready and no new result, out_valid <= 0 and out keeps its value.
- Simultaneous events at one edge:
  - New result + out_ready=1 with out_valid=1: new result loaded, out_valid stays 1, no overrun.
  - New result + out_valid=1 + out_ready=0: new result overwrites out, out_valid stays 1, overrun <= 1.
  - clear + in_valid: clear wins. The sample is dropped, count=0, acc=0. out, out_valid and overrun are unaffected.
  - overrun set + overrun_clear: set wins.
  - rst overrides every other input.
- Reset or clear mid-block: the partial sum is discarded. The next accepted sample starts a new block with a freshly latched ratio.
- in_valid gaps of any length are allowed inside a block; count and acc hold while in_valid=0.

Test Plan:
- log2_ratio=2, out_ready=1, inputs 4, 8, 12, 16 on consecutive cycles -> single out=10 with out_valid high exactly 1 cycle, on the cycle after 16 is presented.
- log2_ratio=1, inputs -1, -2 -> out=-2 (sum -3 >>> 1); inputs 0x7FFFFFFF twice -> out=0x7FFFFFFF (no wrap).
- log2_ratio=0, out_ready=1, inputs 5, -7, 9 back-to-back -> out 5, -7, 9 each 1 cycle later, out_valid continuously high, overrun=0.
- log2_ratio=1, out_ready=0, inputs 2, 2, 6, 6 -> out=2 then overwritten to 6, overrun=1. Then overrun_clear pulse -> overrun=0; out_ready=1 -> out_valid drops next cycle.
- log2_ratio=2, inputs 1, 1. Switch log2_ratio to 1, inputs 1, 1 -> out=1 (old ratio completes block). Next inputs 3, 5 -> out=4 (new ratio).
- log2_ratio=2, inputs 100, 100, then rst (or clear) 1 cycle, then 1, 2, 3, 6 -> out=3. Partial block discarded; after rst, out=0 and out_valid=0 until the new result.
